// File: rtl/rf_ctrl_pkg.sv
// Shared constants and helpers for the register-file write-back controller.
package rf_ctrl_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int NUM_REGS     = 32;
    localparam int XLEN_DEFAULT = 32;

    // Widest flattened bus the slice helper handles: 8 requesters of up to 64 bits.
    localparam int MAX_REQ = 8;
    localparam int MAX_W   = 64;
    localparam int BUS_W   = MAX_REQ * MAX_W;

    // Extract field idx of width bits from a flattened per-requester bus.
    function automatic logic [MAX_W-1:0] slice_bus(input logic [BUS_W-1:0] bus,
                                                   input int width,
                                                   input int idx);
        logic [BUS_W-1:0] shifted;
        logic [MAX_W-1:0] mask;
        shifted = bus >> (width * idx);
        mask    = (width >= MAX_W) ? {MAX_W{1'b1}} : ((MAX_W'(1) << width) - MAX_W'(1));
        return shifted[MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating-priority select starting at ptr_reg, pointer
// advances past the winner whenever a grant is issued.
module rr_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int N = 3,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_id
);

    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] ptr_next;
    logic             found;
    int               idx;
    int               win;

    // Search ptr, ptr+1, ... modulo N for the first valid request.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        win      = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_reg) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        // No grant may be visible while reset is asserted.
        if (rst) begin
            found = 1'b0;
        end
        if (found) begin
            grant[win] = 1'b1;
            grant_id   = IDX_W'(win);
        end
        ptr_next = found ? IDX_W'((win + 1) % N) : ptr_reg;
    end

    // Pointer register; a grant is always a handshake since it implies valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file: round-robin grant among requesters,
// registered write port with x0 suppression, and a busy scoreboard for issue.
module regfile_wb_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int XLEN = XLEN_DEFAULT,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [REG_ADDR_W*NREQ-1:0] req_addr,
    input  logic [XLEN*NREQ-1:0]       req_data,
    output logic                       rf_we,
    output logic [REG_ADDR_W-1:0]      rf_wr,
    output logic [XLEN-1:0]            rf_wd,
    input  logic                       alloc_valid,
    input  logic [REG_ADDR_W-1:0]      alloc_addr,
    output logic [NUM_REGS-1:0]        busy,
    output logic [ID_W-1:0]            grant_id
);

    logic [NREQ-1:0]       grant;
    logic [ID_W-1:0]       gid;
    logic                  hs;
    logic [BUS_W-1:0]      addr_ext;
    logic [BUS_W-1:0]      data_ext;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [XLEN-1:0]       sel_data;

    logic                  rf_we_reg;
    logic [REG_ADDR_W-1:0] rf_wr_reg;
    logic [XLEN-1:0]       rf_wd_reg;
    logic [NUM_REGS-1:0]   busy_reg;
    logic [NUM_REGS-1:0]   busy_next;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .grant    (grant),
        .grant_id (gid)
    );

    assign req_ready = grant;
    assign grant_id  = gid;
    assign hs        = |grant;

    assign addr_ext = BUS_W'(req_addr);
    assign data_ext = BUS_W'(req_data);

    // Mux the granted requester's destination and data onto the write path.
    always_comb begin
        sel_addr = REG_ADDR_W'(slice_bus(addr_ext, REG_ADDR_W, int'(gid)));
        sel_data = XLEN'(slice_bus(data_ext, XLEN, int'(gid)));
    end

    // Registered write port; x0 writes are consumed but never reach the file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_reg <= 1'b0;
            rf_wr_reg <= '0;
            rf_wd_reg <= '0;
        end else begin
            rf_we_reg <= hs && (sel_addr != '0);
            if (hs && (sel_addr != '0)) begin
                rf_wr_reg <= sel_addr;
                rf_wd_reg <= sel_data;
            end
        end
    end

    // Per-bit scoreboard update: a fresh allocation beats a same-edge commit.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            if (gi == 0) begin : g_x0
                assign busy_next[gi] = 1'b0;
            end else begin : g_rn
                assign busy_next[gi] =
                    (alloc_valid && (alloc_addr == REG_ADDR_W'(gi))) ? 1'b1 :
                    (rf_we_reg && (rf_wr_reg == REG_ADDR_W'(gi)))    ? 1'b0 :
                    busy_reg[gi];
            end
        end
    endgenerate

    // Scoreboard state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign rf_we = rf_we_reg;
    assign rf_wr = rf_wr_reg;
    assign rf_wd = rf_wd_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with NREQ=3, XLEN=32.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        rf_we;
    logic [4:0]  rf_wr;
    logic [31:0] rf_wd;
    logic        alloc_valid;
    logic [4:0]  alloc_addr;
    logic [31:0] busy;
    logic [1:0]  grant_id;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf_model [32];

    regfile_wb_arbiter #(.NREQ(3), .XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rf_we       (rf_we),
        .rf_wr       (rf_wr),
        .rf_wd       (rf_wd),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    // Register file stand-in with no x0 protection of its own.
    always @(posedge clk) begin
        if (rf_we) rf_model[rf_wr] <= rf_wd;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[5*i +: 5]  = a;
        req_data[32*i +: 32] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 3'b111;
        alloc_valid = 1'b0;
        alloc_addr = 5'd0;
        set_req(0, 5'd3, 32'h0000_0033);
        set_req(1, 5'd4, 32'h0000_0044);
        set_req(2, 5'd6, 32'h0000_0066);
        #3;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", rf_we); end
        checks++; if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got %b want 000", req_ready); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid got %0d want 0", grant_id); end
        checks++; if (rf_wr !== 5'd0 || rf_wd !== 32'h0) begin errors++; $display("FAIL reset_port got wr=%0d wd=%h want 0/0", rf_wr, rf_wd); end
        tick();
        rst = 1'b0;
        alloc_valid = 1'b1;
        alloc_addr = 5'd9;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL first_grant got %b want 001", req_ready); end
        tick();
        req_valid = 3'b000;
        alloc_valid = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL pre_reset_we got %0b want 1", rf_we); end
        checks++; if (busy !== 32'h0000_0200) begin errors++; $display("FAIL pre_reset_busy got %h want 00000200", busy); end
        rst = 1'b1;
        req_valid = 3'b111;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL midrst_we got %0b want 0", rf_we); end
        checks++; if (busy !== 32'h0) begin errors++; $display("FAIL midrst_busy got %h want 0", busy); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL midrst_ready got %b want 000", req_ready); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL post_rst_grant got %b want 001", req_ready); end
        req_valid = 3'b000;
        $display("test_reset done");
    endtask

    task automatic test_single_write();
        tick();
        set_req(1, 5'd5, 32'hDEAD_BEEF);
        req_valid = 3'b010;
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready got %b want 010", req_ready); end
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL single_gid got %0d want 1", grant_id); end
        tick();
        req_valid = 3'b000;
        checks++; if (rf_we !== 1'b1 || rf_wr !== 5'd5 || rf_wd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL single_port got we=%0b wr=%0d wd=%h want 1/5/deadbeef", rf_we, rf_wr, rf_wd); end
        tick();
        checks++; if (rf_we !== 1'b0 || rf_wr !== 5'd5) begin errors++; $display("FAIL single_after got we=%0b wr=%0d want 0/5", rf_we, rf_wr); end
        checks++; if (rf_model[5] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rf got %h want deadbeef", rf_model[5]); end
        $display("test_single_write done");
    endtask

    task automatic test_x0_write();
        set_req(2, 5'd0, 32'hFFFF_FFFF);
        req_valid = 3'b100;
        #1;
        checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL x0_ready got %b want 100", req_ready); end
        tick();
        req_valid = 3'b000;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we got %0b want 0", rf_we); end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL x0_busy got %0b want 0", busy[0]); end
        tick();
        checks++; if (rf_model[0] !== 32'h0) begin errors++; $display("FAIL x0_read got %h want 0", rf_model[0]); end
        $display("test_x0_write done");
    endtask

    task automatic test_fairness();
        set_req(0, 5'd10, 32'h0000_000A);
        set_req(1, 5'd11, 32'h0000_000B);
        set_req(2, 5'd12, 32'h0000_000C);
        req_valid = 3'b111;
        #1;
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (req_ready !== (3'b001 << (k % 3)) || grant_id !== 2'(k % 3)) begin
                errors++; $display("FAIL fair_grant[%0d] got %b/%0d want id %0d", k, req_ready, grant_id, k % 3);
            end
            if (k > 0) begin
                checks++;
                if (rf_we !== 1'b1 || rf_wr !== 5'(10 + (k - 1) % 3)) begin
                    errors++; $display("FAIL fair_port[%0d] got we=%0b wr=%0d want 1/%0d", k, rf_we, rf_wr, 10 + (k - 1) % 3);
                end
            end
            tick();
        end
        req_valid = 3'b000;
        tick();
        $display("test_fairness done");
    endtask

    task automatic test_scoreboard();
        alloc_valid = 1'b1;
        alloc_addr = 5'd7;
        tick();
        alloc_valid = 1'b0;
        checks++; if (busy !== 32'h0000_0080) begin errors++; $display("FAIL sb_set got %h want 00000080", busy); end
        tick();
        tick();
        set_req(0, 5'd7, 32'h0000_0077);
        req_valid = 3'b001;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL sb_ready got %b want 001", req_ready); end
        tick();
        req_valid = 3'b000;
        alloc_valid = 1'b1;
        alloc_addr = 5'd7;
        checks++; if (rf_we !== 1'b1 || rf_wr !== 5'd7) begin errors++; $display("FAIL sb_commit got we=%0b wr=%0d want 1/7", rf_we, rf_wr); end
        tick();
        alloc_valid = 1'b0;
        checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %0b want 1", busy[7]); end
        set_req(1, 5'd7, 32'h0000_0777);
        req_valid = 3'b010;
        alloc_valid = 1'b1;
        alloc_addr = 5'd0;
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL sb_ready2 got %b want 010", req_ready); end
        tick();
        req_valid = 3'b000;
        alloc_valid = 1'b0;
        checks++; if (busy !== 32'h0000_0080) begin errors++; $display("FAIL sb_x0_alloc got %h want 00000080", busy); end
        tick();
        checks++; if (busy !== 32'h0) begin errors++; $display("FAIL sb_clear got %h want 0", busy); end
        checks++; if (rf_model[7] !== 32'h0000_0777) begin errors++; $display("FAIL sb_rf got %h want 00000777", rf_model[7]); end
        $display("test_scoreboard done");
    endtask

    task automatic test_back_to_back();
        set_req(0, 5'd1, 32'h0000_0001);
        set_req(1, 5'd1, 32'h0000_0002);
        req_valid = 3'b011;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL b2b_first got %b want 001", req_ready); end
        tick();
        req_valid = 3'b010;
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL b2b_second got %b want 010", req_ready); end
        checks++; if (rf_we !== 1'b1 || rf_wr !== 5'd1 || rf_wd !== 32'd1) begin
            errors++; $display("FAIL b2b_w1 got we=%0b wr=%0d wd=%h want 1/1/1", rf_we, rf_wr, rf_wd); end
        tick();
        req_valid = 3'b000;
        checks++; if (rf_we !== 1'b1 || rf_wr !== 5'd1 || rf_wd !== 32'd2) begin
            errors++; $display("FAIL b2b_w2 got we=%0b wr=%0d wd=%h want 1/1/2", rf_we, rf_wr, rf_wd); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0b want 0", rf_we); end
        checks++; if (rf_model[1] !== 32'd2) begin errors++; $display("FAIL b2b_rf got %h want 2", rf_model[1]); end
        $display("test_back_to_back done");
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf_model[r] = 32'h0;
        req_addr = '0;
        req_data = '0;
        test_reset();
        test_single_write();
        test_x0_write();
        test_fairness();
        test_scoreboard();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port among NREQ write-back requesters (ALU, load unit, CSR unit) using round-robin arbitration and valid/ready handshakes. It drives the register file's we/wr/wd from registered outputs and keeps a 32-entry busy scoreboard that issue logic reads to stall on pending destinations. It sits between the execute/memory write-back sources and the register file.

## Interface
- NREQ, 3, number of write-back requesters (2..8)
- XLEN, 32, data width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NREQ  requester i has a write pending
- req_ready  out  NREQ  one-hot grant; handshake when req_valid[i] & req_ready[i]
- req_addr  in  5*NREQ  destination register, requester i at [5i+4:5i]
- req_data  in  XLEN*NREQ  write data, requester i at [XLEN*i+XLEN-1:XLEN*i]
- rf_we  out  1  to register file we
- rf_wr  out  5  to register file wr
- rf_wd  out  XLEN  to register file wd
- alloc_valid  in  1  issue logic marks a destination as pending
- alloc_addr  in  5  destination being allocated
- busy  out  32  scoreboard; bit r = register r has an outstanding write
- grant_id  out  $clog2(NREQ)  index of the requester holding the grant in the current cycle (0 when none)

## Operation
- Round-robin pointer ptr (0..NREQ-1). Each cycle, grant goes to the first i with req_valid[i], searching ptr, ptr+1, … wrapping modulo NREQ. req_ready is combinational and at most one-hot; all zero when no request is valid or rst is high.
- On handshake by requester g: ptr <= (g+1) mod NREQ. Otherwise ptr holds.
- Handshake with req_addr != 0: next cycle rf_we=1, rf_wr=addr, rf_wd=data.
- Handshake with req_addr == 0: the request is accepted and consumed, but rf_we=0 next cycle. The controller enforces x0 as hardwired because the register file does not.
- No handshake: rf_we=0; rf_wr and rf_wd hold their previous values.
- Scoreboard:
  - alloc_valid with alloc_addr != 0 sets busy[alloc_addr].
  - Committing a write clears busy[rf_wr] on the edge that ends the cycle where rf_we=1.
  - Set and clear of the same bit on the same edge: set wins, because the new allocation is younger.
  - alloc to x0 is ignored. busy[0] is constantly 0.
- Requesters must hold valid, addr and data stable until the handshake. The arbiter never withdraws a grant from a requester whose valid stays high in the same cycle.

## Timing
- Reset values (async, immediate): rf_we=0, rf_wr=0, rf_wd=0, busy=0, ptr=0, req_ready=0, grant_id=0.
- Handshake in cycle N:
  - rf_we=1 during N+1; the register file stores the write at the end of N+1.
  - busy bit drops in N+2.
  - A register-file read addressed in N+2 returns the new value in N+3.
- Throughput: one write per cycle. With all NREQ requesters continuously valid, each is granted exactly once per NREQ cycles.
- Reset asserted mid-operation: any in-flight rf_we pulse is killed immediately, the scoreboard clears, and pending requests must be re-presented after reset.
- Same-edge alloc/commit ordering is as stated under Operation.

## Structure
- Package rf_ctrl_pkg holds: REG_ADDR_W=5, NUM_REGS=32, XLEN default, and a function to slice a flattened per-requester bus.
- Sub-module rr_arbiter (parameter N) contains the pointer register and the combinational rotate-priority-select. It outputs the one-hot grant and the binary index.
- Top level contains the registered write-port stage and the busy scoreboard.

## Test plan
- Reset: assert rst mid-cycle with rf_we=1 -> rf_we, busy and req_ready drop to 0 immediately; after release the first grant goes to requester 0.
- Single write: req_valid=3'b010, addr=5, data=32'hDEADBEEF in cycle N -> req_ready=3'b010 in N; rf_we=1, rf_wr=5, rf_wd=DEADBEEF in N+1; rf_we=0 in N+2.
- Fairness: all three requesters held valid for 9 cycles -> grant sequence 0,1,2,0,1,2,0,1,2, with no requester starved or granted twice in a row.
- x0 write: requester 2 writes addr 0, data 32'hFFFFFFFF -> handshake completes, rf_we stays 0, busy[0]=0; a subsequent read of x0 returns 0.
- Scoreboard: alloc r7 in cycle 0 -> busy[7]=1 from cycle 1. Then handshake to r7 in cycle 3 together with a new alloc of r7 on the same commit edge (end of cycle 4) -> busy[7] remains 1.
- Back-to-back: requester 0 writes r1=1 and requester 1 writes r1=2 on consecutive grants -> rf_wr=1 on two consecutive cycles with rf_wd 1 then 2; final r1=2.
